// File: rtl/sobel_grad_pipe.sv
// Sobel gradient stage: one 3x3 window per beat in, gradient magnitude and 2-bit
// quantised direction out through a 3-stage valid/ready pipeline, plus per-frame peak.
module sobel_grad_pipe #(
    parameter int  PIX_W    = 8,
    parameter int  MAG_MODE = 0,
    localparam int MAG_W    = (MAG_MODE == 0) ? PIX_W + 3 : 2 * PIX_W + 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_p11,
    input  logic [PIX_W-1:0] in_p12,
    input  logic [PIX_W-1:0] in_p13,
    input  logic [PIX_W-1:0] in_p21,
    input  logic [PIX_W-1:0] in_p22,
    input  logic [PIX_W-1:0] in_p23,
    input  logic [PIX_W-1:0] in_p31,
    input  logic [PIX_W-1:0] in_p32,
    input  logic [PIX_W-1:0] in_p33,
    input  logic             in_sof,
    input  logic             in_eof,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MAG_W-1:0] out_mag,
    output logic [1:0]       out_dir,
    output logic             out_sof,
    output logic             out_eof,
    output logic [MAG_W-1:0] frame_max,
    output logic             frame_max_valid
);

    localparam int GW = PIX_W + 3;
    localparam int CW = GW + 10;
    localparam logic [CW-1:0] K_TAN22 = CW'(106);
    localparam logic [CW-1:0] K_TAN67 = CW'(618);
    localparam logic [1:0] DIR_N  = 2'b00;
    localparam logic [1:0] DIR_E  = 2'b01;
    localparam logic [1:0] DIR_NW = 2'b10;
    localparam logic [1:0] DIR_NE = 2'b11;

    function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
        return $signed({3'b000, p});
    endfunction

    // Handshake: a beat transfers on a side when valid and ready are both high at a
    // clk edge. The only stall source is a held output (out_valid & ~out_ready); while
    // it lasts every stage holds, in_ready is low, and bubbles move as valid=0.
    logic stall;
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // Centre pixel carries zero weight in both kernels.
    logic unused_p22;
    assign unused_p22 = ^in_p22;

    logic                 s1_valid_q, s1_sof_q, s1_eof_q;
    logic signed [GW-1:0] gx_q, gy_q, gx_d, gy_d;

    always_comb begin
        gx_d = (ext(in_p13) + (ext(in_p23) <<< 1) + ext(in_p33))
             - (ext(in_p11) + (ext(in_p21) <<< 1) + ext(in_p31));
        gy_d = (ext(in_p11) + (ext(in_p12) <<< 1) + ext(in_p13))
             - (ext(in_p31) + (ext(in_p32) <<< 1) + ext(in_p33));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sof_q   <= 1'b0;
            s1_eof_q   <= 1'b0;
            gx_q       <= '0;
            gy_q       <= '0;
        end else if (!stall) begin
            s1_valid_q <= in_valid;
            s1_sof_q   <= in_sof;
            s1_eof_q   <= in_eof;
            gx_q       <= gx_d;
            gy_q       <= gy_d;
        end
    end

    logic          s2_valid_q, s2_sof_q, s2_eof_q, sx_q, sy_q;
    logic [GW-1:0] ax_d, ay_d, ax_q, ay_q;
    logic [CW-1:0] tx_d, ux_d, vy_d, tx_q, ux_q, vy_q;

    // Direction thresholds scaled by 256 so tan(22.5)/tan(67.5) become integer multiplies.
    always_comb begin
        ax_d = gx_q[GW-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
        ay_d = gy_q[GW-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
        tx_d = CW'(ax_d) * K_TAN22;
        ux_d = CW'(ax_d) * K_TAN67;
        vy_d = CW'(ay_d) << 8;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_sof_q   <= 1'b0;
            s2_eof_q   <= 1'b0;
            sx_q       <= 1'b0;
            sy_q       <= 1'b0;
            ax_q       <= '0;
            ay_q       <= '0;
            tx_q       <= '0;
            ux_q       <= '0;
            vy_q       <= '0;
        end else if (!stall) begin
            s2_valid_q <= s1_valid_q;
            s2_sof_q   <= s1_sof_q;
            s2_eof_q   <= s1_eof_q;
            sx_q       <= gx_q[GW-1];
            sy_q       <= gy_q[GW-1];
            ax_q       <= ax_d;
            ay_q       <= ay_d;
            tx_q       <= tx_d;
            ux_q       <= ux_d;
            vy_q       <= vy_d;
        end
    end

    logic [MAG_W-1:0] mag_d;
    logic [1:0]       dir_d;

    always_comb begin
        if (MAG_MODE == 0) begin
            mag_d = MAG_W'(ax_q) + MAG_W'(ay_q);
        end else begin
            mag_d = MAG_W'(ax_q) * MAG_W'(ax_q) + MAG_W'(ay_q) * MAG_W'(ay_q);
        end
        // A zero gradient would otherwise land on the diagonal tie branch.
        if ((ax_q == '0) && (ay_q == '0)) begin
            dir_d = DIR_E;
        end else if (vy_q < tx_q) begin
            dir_d = DIR_E;
        end else if (vy_q > ux_q) begin
            dir_d = DIR_N;
        end else if (sx_q == sy_q) begin
            dir_d = DIR_NE;
        end else begin
            dir_d = DIR_NW;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            out_mag   <= '0;
            out_dir   <= '0;
        end else if (!stall) begin
            out_valid <= s2_valid_q;
            out_sof   <= s2_sof_q;
            out_eof   <= s2_eof_q;
            out_mag   <= mag_d;
            out_dir   <= dir_d;
        end
    end

    logic             out_hs;
    logic [MAG_W-1:0] run_q, run_d;

    assign out_hs = out_valid & out_ready;

    always_comb begin
        run_d = run_q;
        if (out_sof) begin
            run_d = out_mag;
        end else if (out_mag > run_q) begin
            run_d = out_mag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_q           <= '0;
            frame_max       <= '0;
            frame_max_valid <= 1'b0;
        end else begin
            frame_max_valid <= 1'b0;
            if (out_hs) begin
                run_q <= run_d;
                if (out_eof) begin
                    frame_max       <= run_d;
                    frame_max_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sobel_grad_pipe.sv
// Bench for sobel_grad_pipe: table vectors, hand sequences for stall/frame/reset,
// and randomized traffic checked against an integer reference model (L1 and L2 DUTs).
module tb_sobel_grad_pipe;
    localparam int M0_W = 11;
    localparam int M1_W = 21;
    localparam int EW   = 4 + M1_W + M0_W;

    typedef logic [7:0] win_t [9];
    typedef struct {
        win_t             w;
        logic [M0_W-1:0]  mag0;
        logic [M1_W-1:0]  mag1;
        logic [1:0]       dir;
    } vec_t;

    logic clk, rst_n, in_valid, in_sof, in_eof, out_ready;
    logic [7:0] px [9];
    logic in_ready0, out_valid0, out_sof0, out_eof0, fmv0;
    logic in_ready1, out_valid1, out_sof1, out_eof1, fmv1;
    logic [M0_W-1:0] out_mag0, frame_max0;
    logic [M1_W-1:0] out_mag1, frame_max1;
    logic [1:0] out_dir0, out_dir1;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;
    logic [M0_W-1:0] run0, fexp0;
    logic [M1_W-1:0] run1, fexp1;
    logic pend;
    logic rnd_on, seen, rs, re;
    logic [M0_W+3:0] snap;
    win_t w_a, w_b, w10, w6;
    vec_t tbl [12];

    sobel_grad_pipe #(.PIX_W(8), .MAG_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_p11(px[0]), .in_p12(px[1]), .in_p13(px[2]), .in_p21(px[3]), .in_p22(px[4]),
        .in_p23(px[5]), .in_p31(px[6]), .in_p32(px[7]), .in_p33(px[8]),
        .in_sof(in_sof), .in_eof(in_eof), .out_valid(out_valid0), .out_ready(out_ready),
        .out_mag(out_mag0), .out_dir(out_dir0), .out_sof(out_sof0), .out_eof(out_eof0),
        .frame_max(frame_max0), .frame_max_valid(fmv0)
    );

    sobel_grad_pipe #(.PIX_W(8), .MAG_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_p11(px[0]), .in_p12(px[1]), .in_p13(px[2]), .in_p21(px[3]), .in_p22(px[4]),
        .in_p23(px[5]), .in_p31(px[6]), .in_p32(px[7]), .in_p33(px[8]),
        .in_sof(in_sof), .in_eof(in_eof), .out_valid(out_valid1), .out_ready(out_ready),
        .out_mag(out_mag1), .out_dir(out_dir1), .out_sof(out_sof1), .out_eof(out_eof1),
        .frame_max(frame_max1), .frame_max_valid(fmv1)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] pack(input logic sof, input logic eof, input logic [1:0] d,
                                           input int m1, input int m0);
        return {sof, eof, d, M1_W'(m1), M0_W'(m0)};
    endfunction

    // Reference: gradients and direction rule in plain integer arithmetic.
    function automatic logic [EW-1:0] model(input win_t w, input logic sof, input logic eof);
        int p [9];
        int gx, gy, ax, ay;
        logic [1:0] d;
        for (int i = 0; i < 9; i++) p[i] = int'(w[i]);
        gx = (p[2] + 2 * p[5] + p[8]) - (p[0] + 2 * p[3] + p[6]);
        gy = (p[0] + 2 * p[1] + p[2]) - (p[6] + 2 * p[7] + p[8]);
        ax = (gx < 0) ? -gx : gx;
        ay = (gy < 0) ? -gy : gy;
        if (ax == 0 && ay == 0)            d = 2'b01;
        else if (256 * ay < 106 * ax)      d = 2'b01;
        else if (256 * ay > 618 * ax)      d = 2'b00;
        else if ((gx < 0) == (gy < 0))     d = 2'b11;
        else                               d = 2'b10;
        return pack(sof, eof, d, ax * ax + ay * ay, ax + ay);
    endfunction

    function automatic vec_t mk(input int a, input int b, input int c, input int d, input int e,
                                input int f, input int g, input int h, input int i,
                                input int m0, input int m1, input logic [1:0] dir);
        vec_t v;
        v.w = '{8'(a), 8'(b), 8'(c), 8'(d), 8'(e), 8'(f), 8'(g), 8'(h), 8'(i)};
        v.mag0 = M0_W'(m0);
        v.mag1 = M1_W'(m1);
        v.dir  = dir;
        return v;
    endfunction

    function automatic win_t rand_win();
        win_t w;
        for (int i = 0; i < 9; i++) begin
            case ($urandom_range(0, 3))
                0:       w[i] = 8'd0;
                1:       w[i] = 8'd255;
                default: w[i] = 8'($urandom_range(0, 255));
            endcase
        end
        return w;
    endfunction

    // driver: called at posedge+1, returns at posedge+1 after the handshake edge
    task automatic send_beat(input win_t w, input logic sof, input logic eof, input logic [EW-1:0] exp);
        logic ok;
        for (int i = 0; i < 9; i++) px[i] = w[i];
        in_sof = sof;
        in_eof = eof;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (in_ready0 === 1'b1) ok = 1'b1;
        end
        if (ok) exp_q.push_back(exp);
        else begin
            checks++;
            errors++;
            $display("FAIL in_handshake: in_ready stayed 0, expected 1 within 200 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof = 1'b0;
        in_eof = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(posedge clk);
        #1;
        chk(name, exp_q.size(), 0);
    endtask

    // scoreboard / frame-max model
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                run0 = '0; run1 = '0; fexp0 = '0; fexp1 = '0; pend = 1'b0;
            end else begin
                chk("frame_max_valid", fmv0, pend);
                chk("frame_max_valid_l2", fmv1, pend);
                chk("frame_max", frame_max0, fexp0);
                chk("frame_max_l2", frame_max1, fexp1);
                pend = 1'b0;
                if (out_valid0 && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL out_unexpected: got beat mag %0d, expected no output", out_mag0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("out_mag", out_mag0, mon_e[M0_W-1:0]);
                        chk("out_mag_l2", out_mag1, mon_e[M1_W+M0_W-1:M0_W]);
                        chk("out_dir", out_dir0, mon_e[33:32]);
                        chk("out_dir_l2", out_dir1, mon_e[33:32]);
                        chk("out_sof", {out_sof0, out_sof1}, {2{mon_e[35]}});
                        chk("out_eof", {out_eof0, out_eof1}, {2{mon_e[34]}});
                        chk("out_valid_l2", out_valid1, 1);
                        if (mon_e[35]) begin
                            run0 = mon_e[M0_W-1:0];
                            run1 = mon_e[M1_W+M0_W-1:M0_W];
                        end else begin
                            if (mon_e[M0_W-1:0] > run0) run0 = mon_e[M0_W-1:0];
                            if (mon_e[M1_W+M0_W-1:M0_W] > run1) run1 = mon_e[M1_W+M0_W-1:M0_W];
                        end
                        if (mon_e[34]) begin
                            fexp0 = run0;
                            fexp1 = run1;
                            pend = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        tbl[0]  = mk(100,100,100, 100,100,100, 100,100,100,    0,       0, 2'b01);
        tbl[1]  = mk(  0,  0,255,   0,  0,255,   0,  0,255, 1020, 1040400, 2'b01);
        tbl[2]  = mk(255,255,255, 128,128,128,   0,  0,  0, 1020, 1040400, 2'b00);
        tbl[3]  = mk(  0,  0,  0, 128,128,128, 255,255,255, 1020, 1040400, 2'b00);
        tbl[4]  = mk(  0,200,200,   0,  0,200,   0,  0,  0, 1200,  720000, 2'b11);
        tbl[5]  = mk(200,200,  0, 200,  0,  0,   0,  0,  0, 1200,  720000, 2'b10);
        tbl[6]  = mk(  0, 53,  0,   0,  0,128,   0,  0,  0,  362,   76772, 2'b11);
        tbl[7]  = mk( 54,255, 54,   0,  0,128,   0,  0,  0,  874,  447460, 2'b11);
        tbl[8]  = mk(  0, 52,  0,   0,  0,128,   0,  0,  0,  360,   76352, 2'b01);
        tbl[9]  = mk(  0, 10,  0,   0,  0,  0,   0,  0,  0,   20,     400, 2'b00);
        tbl[10] = mk(  0,  0,  0,   0,  0,  0, 255,  0,  0,  510,  130050, 2'b11);
        tbl[11] = mk( 55,255, 55,   0,  0,128,   0,  0,  0,  876,  449936, 2'b00);
        w10 = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd5, 8'd0, 8'd0, 8'd0};
        w6  = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd3, 8'd0, 8'd0, 8'd0};

        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
        out_ready = 1'b1; rnd_on = 1'b0; seen = 1'b0;
        for (int i = 0; i < 9; i++) px[i] = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {out_valid0, out_valid1}, 0);
        chk("rst_out_mag", out_mag0, 0);
        chk("rst_out_dir", out_dir0, 0);
        chk("rst_frame_max", {frame_max0, frame_max1}, 0);
        chk("rst_frame_max_valid", {fmv0, fmv1}, 0);
        chk("rst_in_ready", {in_ready0, in_ready1}, 2'b11);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // T1: latency of a flat window
        send_beat(tbl[0].w, 1'b0, 1'b0, pack(1'b0, 1'b0, tbl[0].dir, int'(tbl[0].mag1), int'(tbl[0].mag0)));
        @(negedge clk); chk("t1_lat_cycle1", out_valid0, 0);
        @(negedge clk); chk("t1_lat_cycle2", out_valid0, 0);
        @(negedge clk); chk("t1_lat_cycle3", out_valid0, 1);
        @(posedge clk);
        #1;

        // table vectors, back to back
        for (int i = 0; i < 12; i++)
            send_beat(tbl[i].w, 1'b0, 1'b0, pack(1'b0, 1'b0, tbl[i].dir, int'(tbl[i].mag1), int'(tbl[i].mag0)));
        drain("table_drain");

        // T5: ten-beat stream with a five-cycle output stall
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    w_a = rand_win();
                    send_beat(w_a, 1'b0, 1'b0, model(w_a, 1'b0, 1'b0));
                end
            end
            begin
                seen = 1'b0;
                for (int t = 0; t < 100 && !seen; t++) begin
                    @(negedge clk);
                    if (out_valid0) seen = 1'b1;
                end
                chk("t5_first_out", seen, 1);
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                snap = {out_mag0, out_dir0, out_sof0, out_eof0};
                for (int c = 0; c < 5; c++) begin
                    if (c > 0) @(negedge clk);
                    chk("t5_in_ready_low", {in_ready0, in_ready1}, 0);
                    chk("t5_out_valid_held", out_valid0, 1);
                    chk("t5_out_frozen", {out_mag0, out_dir0, out_sof0, out_eof0}, snap);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("t5_drain");

        // T6: four-pixel frame, mags 10,1020,6,0
        send_beat(w10, 1'b1, 1'b0, pack(1'b1, 1'b0, 2'b01, 100, 10));
        send_beat(tbl[1].w, 1'b0, 1'b0, pack(1'b0, 1'b0, 2'b01, 1040400, 1020));
        send_beat(w6, 1'b0, 1'b0, pack(1'b0, 1'b0, 2'b01, 36, 6));
        send_beat(tbl[0].w, 1'b0, 1'b1, pack(1'b0, 1'b1, 2'b01, 0, 0));
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (out_valid0 && out_eof0) seen = 1'b1;
        end
        chk("t6_eof_out", seen, 1);
        chk("t6_pulse_not_early", fmv0, 0);
        @(negedge clk);
        chk("t6_pulse", fmv0, 1);
        chk("t6_frame_max", frame_max0, 1020);
        chk("t6_frame_max_l2", frame_max1, 1040400);
        @(negedge clk);
        chk("t6_pulse_one_cycle", fmv0, 0);
        chk("t6_frame_max_hold", frame_max0, 1020);
        @(posedge clk);
        #1;

        // reset with beats in flight
        send_beat(tbl[1].w, 1'b1, 1'b0, pack(1'b1, 1'b0, 2'b01, 1040400, 1020));
        send_beat(tbl[4].w, 1'b0, 1'b0, pack(1'b0, 1'b0, 2'b11, 720000, 1200));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", {out_valid0, out_valid1}, 0);
        chk("midrst_frame_max", {frame_max0, frame_max1}, 0);
        chk("midrst_frame_max_valid", fmv0, 0);
        repeat (6) @(posedge clk);
        #1;

        // randomized traffic with random backpressure and frame markers
        rnd_on = 1'b1;
        fork
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                for (int i = 0; i < 80; i++) begin
                    if ($urandom_range(0, 2) == 0) begin
                        repeat ($urandom_range(1, 2)) @(posedge clk);
                        #1;
                    end
                    w_b = rand_win();
                    rs = ($urandom_range(0, 5) == 0);
                    re = ($urandom_range(0, 5) == 0);
                    send_beat(w_b, rs, re, model(w_b, rs, re));
                end
                rnd_on = 1'b0;
            end
        join
        out_ready = 1'b1;
        drain("random_drain");
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
